seq_stimulus_ctrl: RTL and testbench
====================================

SEQ_STIMULUS_CTRL -- requirements
Module: seq_stimulus_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 16, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 5, width of the hit counter, equal to clog2(PAT_W+1).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle run request.
REQ-006 pattern  input  PAT_W  stimulus bits, LSB driven first.
REQ-007 len  input  CNT_W  number of bits to drive; 0 = invalid; >PAT_W clamped to PAT_W.
REQ-008 z_bin  input  1  Moore output of the binary-encoded sequence detector.
REQ-009 z_oh  input  1  Moore output of the one-hot sequence detector.
REQ-010 w  output  1  registered serial stimulus to both detectors.
REQ-011 det_rst  output  1  active-high reset to both detectors.
REQ-012 busy  output  1  high from CLEAR through RUN.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 hit_count  output  CNT_W  count of sampled cycles with z_bin=1.
REQ-015 mismatch  output  1  sticky; set if z_bin!=z_oh in any sampled cycle.

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: start=1 with len!=0 SHALL latch pattern and clamped len, clear hit_count and mismatch, and go to CLEAR.
REQ-018 start with len=0, or start in any state other than IDLE, SHALL be ignored with no output change.
REQ-019 CLEAR SHALL last exactly one cycle with det_rst=1 and w=0, then go to RUN with idx=0.
REQ-020 RUN: w SHALL equal pattern[idx] for idx<len and 0 at idx=len; idx increments by 1 each cycle.
REQ-021 RUN: in cycles with idx>=1, z_bin and z_oh SHALL be sampled (they reflect bits 0..idx-1).
REQ-022 Each sampled cycle with z_bin=1 SHALL increment hit_count; hit_count saturates at PAT_W.
REQ-023 A sampled cycle with z_bin!=z_oh SHALL set mismatch, which stays set until the next accepted start.
REQ-024 RUN SHALL last exactly len+1 cycles and go to DONE after the idx=len cycle.
REQ-025 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-026 hit_count and mismatch SHALL hold their values in IDLE until the next accepted start.
REQ-027 Latency from accepted start to done SHALL be len+3 cycles (start edge, CLEAR, RUN len+1, DONE).
REQ-028 det_rst SHALL be 0 in IDLE, RUN and DONE.
REQ-029 w SHALL be 0 outside RUN.

Reset
REQ-030 Asserting reset (low) SHALL immediately force state=IDLE, w=0, busy=0, done=0, hit_count=0, mismatch=0, idx=0.
REQ-031 det_rst SHALL be 1 while reset is asserted, so the detectors clear together with this block.
REQ-032 Reset mid-run SHALL abandon the run; no done pulse SHALL be produced.
REQ-033 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-034 The shared package SHALL hold the state enum (IDLE, CLEAR, RUN, DONE) and the constants PAT_W and CNT_W.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 The stimulus SHALL use a PAT_W-bit shift register and an index counter of CNT_W bits.

Verification
The bench drives z_bin and z_oh from a model that asserts z when the last two w samples are both 1.
REQ-037 pattern=16'h00FF, len=8, start -> done 11 cycles after start; hit_count=7; mismatch=0.
REQ-038 pattern=16'h5555, len=16 -> hit_count=0; w toggles 1,0,1,... for 16 cycles; mismatch=0.
REQ-039 pattern=16'hFFFF, len=20 -> treated as len 16; hit_count=15; done 19 cycles after start.
REQ-040 len=8, z_oh forced low for one sampled cycle where the model gives z=1 -> mismatch=1, hit_count=7; the next start clears mismatch.
REQ-041 start with len=0, and start during RUN -> ignored: no busy change, outputs unchanged.
REQ-042 reset low at RUN idx=3 -> outputs zero at once, det_rst=1, no done pulse; a new run after release completes normally.

Source files
------------

// File: rtl/seq_stimulus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_stimulus_ctrl_pkg
// Shared definitions for the sequence-detector stimulus controller:
//   - PAT_W : default maximum pattern length in bits
//   - CNT_W : default width of the length/index/hit counters (clog2(PAT_W+1))
//   - state_e : controller states IDLE -> CLEAR -> RUN -> DONE
// ---------------------------------------------------------------------------
package seq_stimulus_ctrl_pkg;

  localparam int PAT_W = 16;
  localparam int CNT_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : seq_stimulus_ctrl_pkg

// File: rtl/seq_stimulus_ctrl.sv
// ---------------------------------------------------------------------------
// seq_stimulus_ctrl
// Drives a serial bit pattern into two sequence detectors (one binary-encoded,
// one one-hot) and compares their Moore outputs cycle by cycle.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   reset     in   asynchronous reset, active low
//   start     in   one-cycle run request, honoured only in IDLE with len != 0
//   pattern   in   [PAT_W] stimulus bits, LSB is driven first
//   len       in   [CNT_W] number of bits to drive, values above PAT_W clamp
//   z_bin     in   Moore output of the binary-encoded detector
//   z_oh      in   Moore output of the one-hot detector
//   w         out  registered serial stimulus to both detectors
//   det_rst   out  active-high reset for both detectors
//   busy      out  high during CLEAR and RUN
//   done      out  one-cycle pulse when a run completes
//   hit_count out  [CNT_W] sampled cycles with z_bin = 1, saturating at PAT_W
//   mismatch  out  sticky flag, set when z_bin != z_oh in a sampled cycle
// ---------------------------------------------------------------------------
module seq_stimulus_ctrl #(
  parameter int PAT_W = seq_stimulus_ctrl_pkg::PAT_W,
  parameter int CNT_W = seq_stimulus_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             z_bin,
  input  logic             z_oh,
  output logic             w,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             mismatch
);

  import seq_stimulus_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] PAT_LEN_MAX = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             w_q, w_d;
  logic             mis_q, mis_d;

  logic [CNT_W-1:0] len_clamped;
  logic [CNT_W-1:0] idx_next;

  assign len_clamped = (len > PAT_LEN_MAX) ? PAT_LEN_MAX : len;
  assign idx_next    = idx_q + CNT_ONE;

  // State and datapath registers. Everything clears asynchronously so an
  // abandoned run leaves no trace and can never reach DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      w_q     <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      w_q     <= w_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and datapath logic.
  // w is registered, so the bit for RUN index i is prepared in the cycle
  // before: CLEAR loads bit 0, and RUN index i loads bit i+1. The pattern is
  // kept in a shift register so the next bit to drive is always pat_q[0].
  // Once the index reaches len the stimulus is forced low for the final
  // sampling cycle.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    w_d     = 1'b0;
    mis_d   = mis_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_CLEAR;
          pat_d   = pattern;
          len_d   = len_clamped;
          idx_d   = '0;
          hit_d   = '0;
          mis_d   = 1'b0;
        end
      end

      ST_CLEAR: begin
        state_d = ST_RUN;
        idx_d   = '0;
        w_d     = pat_q[0];
        pat_d   = pat_q >> 1;
      end

      ST_RUN: begin
        // Index 0 is skipped: the detectors have not seen any bit yet.
        if (idx_q != '0) begin
          if (z_bin && (hit_q != PAT_LEN_MAX)) begin
            hit_d = hit_q + CNT_ONE;
          end
          if (z_bin != z_oh) begin
            mis_d = 1'b1;
          end
        end

        if (idx_q == len_q) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_next;
          if (idx_next < len_q) begin
            w_d   = pat_q[0];
            pat_d = pat_q >> 1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state. det_rst also follows the
  // block reset directly so the detectors clear together with this block.
  assign w         = w_q;
  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign det_rst   = (!reset) || (state_q == ST_CLEAR);
  assign hit_count = hit_q;
  assign mismatch  = mis_q;

endmodule : seq_stimulus_ctrl

// File: tb/tb_seq_stimulus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_stimulus_ctrl
// Self-checking bench for seq_stimulus_ctrl. Both detector inputs come from a
// small two-sample "11" detector model driven by w; z_oh can be forced low
// for a single cycle to provoke a disagreement. Expected results are derived
// directly from the pattern bits.
// ---------------------------------------------------------------------------
module tb_seq_stimulus_ctrl;

  localparam int PAT_W = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic             z_bin;
  logic             z_oh;
  logic             w;
  logic             det_rst;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             mismatch;

  logic [1:0] det_hist;
  logic       force_low;
  int         n_checks;
  int         n_fail;

  seq_stimulus_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .z_bin     (z_bin),
    .z_oh      (z_oh),
    .w         (w),
    .det_rst   (det_rst),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model: z is high when the last two sampled w values were 1.
  always @(posedge clk) begin
    if (det_rst) det_hist <= 2'b00;
    else         det_hist <= {det_hist[0], w};
  end

  assign z_bin = &det_hist;
  assign z_oh  = force_low ? 1'b0 : (&det_hist);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected hits: a sampled cycle i (1..L) sees z=1 when bits i-1 and i-2
  // were both driven as 1.
  function automatic int expHits(input logic [PAT_W-1:0] p, input int l);
    int n = 0;
    for (int i = 2; i <= l; i++) begin
      if (p[i-1] && p[i-2]) n++;
    end
    return n;
  endfunction

  // One complete run. force_idx selects a RUN index whose z_oh is pulled low
  // (-1 for none); mid_idx selects a RUN index in which a stray start is
  // driven (-1 for none). Called #1 after a rising edge, with the DUT idle.
  task automatic applyStimulus(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] l_in,
                               input int force_idx, input int mid_idx);
    int l;
    int e_hits;
    logic e_mis;
    logic e_w;
    int cycles;
    l      = (int'(l_in) > PAT_W) ? PAT_W : int'(l_in);
    e_hits = expHits(p, l);
    e_mis  = (force_idx >= 2 && force_idx <= l) ? (p[force_idx-1] && p[force_idx-2]) : 1'b0;

    start   = 1'b1;
    pattern = p;
    len     = l_in;
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = PAT_W'($urandom);
    len     = CNT_W'($urandom);
    cycles  = 1;
    checkOutput("clear_busy", busy, 1);
    checkOutput("clear_det_rst", det_rst, 1);
    checkOutput("clear_w", w, 0);
    checkOutput("clear_hit", hit_count, 0);
    checkOutput("clear_mismatch", mismatch, 0);

    for (int idx = 0; idx <= l; idx++) begin
      @(posedge clk); #1;
      cycles++;
      force_low = 1'b0;
      start     = 1'b0;
      e_w = (idx < l) ? p[idx] : 1'b0;
      checkOutput($sformatf("run_w_idx%0d", idx), w, e_w);
      checkOutput("run_busy", busy, 1);
      checkOutput("run_done", done, 0);
      checkOutput("run_det_rst", det_rst, 0);
      if (idx == force_idx) force_low = 1'b1;
      if (idx == mid_idx) begin
        start = 1'b1;
        len   = 5'd3;
      end
    end

    @(posedge clk); #1;
    cycles++;
    force_low = 1'b0;
    start     = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_latency", cycles, l + 3);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_w", w, 0);
    checkOutput("done_hits", hit_count, e_hits);
    checkOutput("done_mismatch", mismatch, e_mis);

    @(posedge clk); #1;
    checkOutput("idle_done", done, 0);
    checkOutput("idle_hits_hold", hit_count, e_hits);
    checkOutput("idle_mismatch_hold", mismatch, e_mis);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    force_low = 1'b0;
    start     = 1'b0;
    pattern   = '0;
    len       = '0;
    reset     = 1'b0;
    #1;
    checkOutput("reset_w", w, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_hits", hit_count, 0);
    checkOutput("reset_mismatch", mismatch, 0);
    checkOutput("reset_det_rst", det_rst, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_det_rst", det_rst, 0);

    $display("[TB] directed: 00FF len 8");
    applyStimulus(16'h00FF, 5'd8, -1, -1);

    $display("[TB] start with len 0 is ignored");
    start = 1'b1;
    len   = 5'd0;
    pattern = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("len0_busy", busy, 0);
      checkOutput("len0_hits", hit_count, 7);
      checkOutput("len0_mismatch", mismatch, 0);
    end

    $display("[TB] directed: 5555 len 16");
    applyStimulus(16'h5555, 5'd16, -1, -1);

    $display("[TB] directed: FFFF len 20 clamps to 16");
    applyStimulus(16'hFFFF, 5'd20, -1, -1);

    $display("[TB] directed: forced disagreement, then a clean run");
    applyStimulus(16'h00FF, 5'd8, 5, -1);
    applyStimulus(16'h00FF, 5'd8, -1, -1);

    $display("[TB] start during RUN is ignored");
    applyStimulus(16'h0F3B, 5'd12, -1, 4);

    $display("[TB] reset during RUN");
    start   = 1'b1;
    pattern = 16'hFFFF;
    len     = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("prereset_hits", hit_count, 1);
    checkOutput("prereset_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_w", w, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_hits", hit_count, 0);
    checkOutput("midreset_mismatch", mismatch, 0);
    checkOutput("midreset_det_rst", det_rst, 1);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("inreset_done", done, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checkOutput("postreset_done", done, 0);
      checkOutput("postreset_busy", busy, 0);
    end
    applyStimulus(16'hFFFF, 5'd8, -1, -1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(PAT_W'($urandom), CNT_W'($urandom_range(1, 31)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_stimulus_ctrl
